// File: rtl/jk_universal_reg.sv
// WIDTH-bit register with per-bit JK control, modulo-MOD up/down counting and
// clamped parallel load. Q and ovf are registered; nQ and tc are combinational.
module jk_universal_reg #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MOD     = 16,
  parameter int unsigned RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] nQ,
  output logic             tc,
  output logic             ovf
);

  typedef enum logic [1:0] {
    MODE_JK   = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DOWN = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  localparam int unsigned WIDTH_EXT = WIDTH + 1;
  localparam logic [WIDTH-1:0]     MAX_VAL = WIDTH'(MOD - 1);
  // One extra bit so MOD == 2**WIDTH is representable for range checks.
  localparam logic [WIDTH_EXT-1:0] MOD_EXT = WIDTH_EXT'(MOD);
  localparam logic [WIDTH-1:0]     RST_Q   = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] q_next;
  logic             ovf_next;

  // Next-state selection by mode; en=0 holds Q and clears ovf.
  always_comb begin
    q_next   = Q;
    ovf_next = 1'b0;
    if (en) begin
      case (mode)
        MODE_JK: begin
          for (int i = 0; i < int'(WIDTH); i++) begin
            case ({J[i], K[i]})
              2'b10:   q_next[i] = 1'b1;
              2'b01:   q_next[i] = 1'b0;
              2'b11:   q_next[i] = ~Q[i];
              default: q_next[i] = Q[i];
            endcase
          end
        end
        MODE_UP: begin
          if (Q >= MAX_VAL) begin
            q_next   = '0;
            ovf_next = 1'b1;
          end else begin
            q_next = Q + WIDTH'(1);
          end
        end
        MODE_DOWN: begin
          if (Q == '0) begin
            q_next   = MAX_VAL;
            ovf_next = 1'b1;
          end else if ({1'b0, Q} >= MOD_EXT) begin
            q_next = MAX_VAL;
          end else begin
            q_next = Q - WIDTH'(1);
          end
        end
        MODE_LOAD: begin
          q_next = ({1'b0, d} < MOD_EXT) ? d : MAX_VAL;
        end
        default: q_next = Q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      Q   <= RST_Q;
      ovf <= 1'b0;
    end else begin
      Q   <= q_next;
      ovf <= ovf_next;
    end
  end

  assign nQ = ~Q;
  // Predicts a wrap on the next enabled edge.
  assign tc = en & (((mode == MODE_UP) & (Q >= MAX_VAL)) |
                    ((mode == MODE_DOWN) & (Q == '0)));

endmodule

// File: tb/tb_jk_universal_reg.sv
// Bench for jk_universal_reg: MOD=10 and MOD=16 instances share stimulus and are
// compared each cycle against an integer reference model plus literal spot checks.
module tb_jk_universal_reg;

  logic       clk = 1'b0;
  logic       rst, en;
  logic [1:0] mode;
  logic [3:0] J, K, d;
  logic [3:0] q10, nq10, q16, nq16;
  logic       tc10, ovf10, tc16, ovf16;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  int m_q10, m_ovf10, m_q16, m_ovf16;

  always #5 clk = ~clk;

  jk_universal_reg #(.WIDTH(4), .MOD(10), .RST_VAL(0)) dut10 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .J(J), .K(K), .d(d),
    .Q(q10), .nQ(nq10), .tc(tc10), .ovf(ovf10)
  );

  jk_universal_reg #(.WIDTH(4), .MOD(16), .RST_VAL(0)) dut16 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .J(J), .K(K), .d(d),
    .Q(q16), .nQ(nq16), .tc(tc16), .ovf(ovf16)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
  endtask

  // Reference behaviour: JK uses the characteristic equation Q+ = J~Q | ~K Q.
  function automatic void model_step(input int modv, input int q, output int qn, output int of);
    qn = q;
    of = 0;
    case (int'(mode))
      0: qn = ((int'(J) & ~q) | (~int'(K) & q)) & 15;
      1: begin
        if (q >= modv - 1) begin qn = 0; of = 1; end
        else qn = q + 1;
      end
      2: begin
        if (q == 0) begin qn = modv - 1; of = 1; end
        else if (q >= modv) qn = modv - 1;
        else qn = q - 1;
      end
      default: qn = (int'(d) < modv) ? int'(d) : modv - 1;
    endcase
  endfunction

  function automatic int model_tc(input int modv, input int q);
    return (en && ((mode == 2'd1 && q >= modv - 1) || (mode == 2'd2 && q == 0))) ? 1 : 0;
  endfunction

  always @(posedge clk) begin
    int qn, of;
    if (rst) begin
      m_q10 = 0; m_ovf10 = 0; m_q16 = 0; m_ovf16 = 0;
    end else if (!en) begin
      m_ovf10 = 0; m_ovf16 = 0;
    end else begin
      model_step(10, m_q10, qn, of); m_q10 = qn; m_ovf10 = of;
      model_step(16, m_q16, qn, of); m_q16 = qn; m_ovf16 = of;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m10_q",   int'(q10),  m_q10);
      check("m10_nq",  int'(nq10), (~m_q10) & 15);
      check("m10_tc",  int'(tc10), model_tc(10, m_q10));
      check("m10_ovf", int'(ovf10), m_ovf10);
      check("m16_q",   int'(q16),  m_q16);
      check("m16_nq",  int'(nq16), (~m_q16) & 15);
      check("m16_tc",  int'(tc16), model_tc(16, m_q16));
      check("m16_ovf", int'(ovf16), m_ovf16);
    end
  end

  task automatic drive(input logic r, input logic e, input logic [1:0] m,
                       input logic [3:0] j, input logic [3:0] k, input logic [3:0] dd);
    rst = r; en = e; mode = m; J = j; K = k; d = dd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b1, 1'b0, 2'd0, 4'h0, 4'h0, 4'h0);
    tick();
    chk_en = 1'b1;

    // Reset state
    check("rst_q", int'(q10), 0);
    check("rst_nq", int'(nq10), 15);
    check("rst_ovf", int'(ovf10), 0);
    check("rst_tc", int'(tc10), 0);

    // Load then per-bit JK
    drive(1'b0, 1'b1, 2'd3, 4'h0, 4'h0, 4'd3); tick();
    check("load3_q", int'(q10), 3);
    drive(1'b0, 1'b1, 2'd0, 4'b1010, 4'b0110, 4'd0); tick();
    check("jk_q", int'(q10), 9);
    check("jk_nq", int'(nq10), 6);

    // Count up through the wrap
    drive(1'b0, 1'b1, 2'd3, 4'h0, 4'h0, 4'd8); tick();
    drive(1'b0, 1'b1, 2'd1, 4'h0, 4'h0, 4'd0); tick();
    check("up_q9", int'(q10), 9);
    check("up_tc", int'(tc10), 1);
    tick();
    check("up_wrap_q", int'(q10), 0);
    check("up_wrap_ovf", int'(ovf10), 1);
    tick();
    check("up_after_q", int'(q10), 1);
    check("up_after_ovf", int'(ovf10), 0);

    // Down wrap, clamp on load, out-of-range down
    drive(1'b0, 1'b1, 2'd3, 4'h0, 4'h0, 4'd0); tick();
    drive(1'b0, 1'b1, 2'd2, 4'h0, 4'h0, 4'd0); #1;
    check("dn_tc", int'(tc10), 1);
    tick();
    check("dn_wrap_q", int'(q10), 9);
    check("dn_wrap_ovf", int'(ovf10), 1);
    drive(1'b0, 1'b1, 2'd3, 4'h0, 4'h0, 4'd12); tick();
    check("clamp_q", int'(q10), 9);
    check("clamp16_q", int'(q16), 12);
    drive(1'b0, 1'b1, 2'd0, 4'hF, 4'h0, 4'd0); tick();
    check("jkset_q", int'(q10), 15);
    drive(1'b0, 1'b1, 2'd2, 4'h0, 4'h0, 4'd0); tick();
    check("dn_oor_q", int'(q10), 9);
    check("dn_oor_ovf", int'(ovf10), 0);

    // Back-to-back wraps: 9 -up-> 0 -down-> 9
    drive(1'b0, 1'b1, 2'd1, 4'h0, 4'h0, 4'd0); tick();
    check("b2b1_ovf", int'(ovf10), 1);
    drive(1'b0, 1'b1, 2'd2, 4'h0, 4'h0, 4'd0); tick();
    check("b2b2_q", int'(q10), 9);
    check("b2b2_ovf", int'(ovf10), 1);

    // Hold with en=0 across all modes, then reset while disabled
    drive(1'b0, 1'b1, 2'd3, 4'h0, 4'h0, 4'd5); tick();
    for (int m = 0; m < 4; m++) begin
      drive(1'b0, 1'b0, 2'(m), 4'($urandom), 4'($urandom), 4'($urandom)); tick();
    end
    check("hold_q", int'(q10), 5);
    check("hold_ovf", int'(ovf10), 0);
    drive(1'b1, 1'b0, 2'd1, 4'h0, 4'h0, 4'd0); tick();
    check("rst_dis_q", int'(q10), 0);

    // Full-range binary wrap
    drive(1'b0, 1'b1, 2'd3, 4'h0, 4'h0, 4'd15); tick();
    drive(1'b0, 1'b1, 2'd1, 4'h0, 4'h0, 4'd0); tick();
    check("m16_wrap_q", int'(q16), 0);
    check("m16_wrap_ovf", int'(ovf16), 1);

    // Sweep all J/K combinations
    for (int j = 0; j < 16; j++) begin
      for (int k = 0; k < 16; k++) begin
        drive(1'b0, 1'b1, 2'd0, 4'(j), 4'(k), 4'd0); tick();
      end
    end

    // Random traffic with occasional resets and disables
    for (int n = 0; n < 2000; n++) begin
      drive(($urandom_range(0, 31) == 0), ($urandom_range(0, 5) != 0), 2'($urandom),
            4'($urandom), 4'($urandom), 4'($urandom));
      tick();
    end

    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
